// File: rtl/spi_tx_queue.sv
// Byte queue feeding the SPI slave MISO path: 32-bit words are serialized MSB-first into a byte FIFO.
// Latency: a word accepted at edge N shows its first byte on spi_din after N+1; busy while serializing or low on space.
module spi_tx_queue #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [7:0]  IDLE_BYTE  = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [31:0]           s_data,
    input  logic                  s_drdy,
    input  logic                  spi_done,
    output logic [7:0]            spi_din,
    output logic                  busy,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    // Highest level at which a whole 4-byte word still fits.
    localparam logic [DEPTH_LOG2:0] MAX_ACCEPT = LW'(DEPTH - 4);

    typedef enum logic {IDLE, PUSH} state_t;

    state_t                  state;
    logic [1:0]              idx;
    logic [31:0]             word_q;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic                    wr_en;
    logic                    pop;
    logic [7:0]              wr_byte;

    assign wr_en   = (state == PUSH) && !flush;
    assign pop     = spi_done && (level != '0) && !flush;
    assign busy    = (state == PUSH) || (level > MAX_ACCEPT);
    assign empty   = (level == '0);
    assign spi_din = empty ? IDLE_BYTE : mem[rd_ptr];

    always_comb begin
        wr_byte = word_q[31:24];
        case (idx)
            2'd0: wr_byte = word_q[31:24];
            2'd1: wr_byte = word_q[23:16];
            2'd2: wr_byte = word_q[15:8];
            2'd3: wr_byte = word_q[7:0];
            default: wr_byte = word_q[31:24];
        endcase
    end

    // Storage needs no reset; level gates every read of it.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            word_q    <= 32'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (flush) begin
                state  <= IDLE;
                idx    <= 2'd0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (s_drdy) begin
                            if (busy) begin
                                overflow <= 1'b1;
                            end else begin
                                word_q <= s_data;
                                idx    <= 2'd0;
                                state  <= PUSH;
                            end
                        end
                    end
                    PUSH: begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase

                if (wr_en)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                level <= level + LW'(wr_en) - LW'(pop);

                if (spi_done && (level == '0))
                    underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_queue.sv
// Self-checking bench for spi_tx_queue: cycle table for reset/single-word behaviour,
// hand sequences for fill/overflow, wrap with concurrent pops, flush and async reset.
module tb_spi_tx_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] s_data;
    logic        s_drdy;
    logic        spi_done;
    logic [7:0]  spi_din;
    logic        busy;
    logic        empty;
    logic [4:0]  level;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    spi_tx_queue #(.DEPTH_LOG2(4), .IDLE_BYTE(8'hFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .s_data    (s_data),
        .s_drdy    (s_drdy),
        .spi_done  (spi_done),
        .spi_din   (spi_din),
        .busy      (busy),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        drdy;
        logic [31:0] data;
        logic        done;
        logic [7:0]  din;
        logic [4:0]  lvl;
        logic        busy;
        logic        empty;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after an edge; outputs are sampled 1ns after the next edge.
    task automatic step(input logic drdy_i, input logic [31:0] data_i,
                        input logic done_i, input logic flush_i);
        s_drdy   = drdy_i;
        s_data   = data_i;
        spi_done = done_i;
        flush    = flush_i;
        @(posedge clk);
        #1;
        s_drdy   = 1'b0;
        spi_done = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        step(1'b1, w, 1'b0, 1'b0);
        repeat (4) step(1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic drain_word(input string name, input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            logic [7:0] eb;
            eb = w[31 - 8*b -: 8];
            chk(name, {24'd0, spi_din}, {24'd0, eb});
            step(1'b0, 32'd0, 1'b1, 1'b0);
        end
        chk({name, "_idle"}, {24'd0, spi_din}, 32'h0000_00FF);
        chk({name, "_empty"}, {31'd0, empty}, 32'd1);
    endtask

    // A FIFO write must never land on a full FIFO.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (dut.wr_en && level == 5'd16) begin
                errors++;
                $display("FAIL write_while_full: level %0d, write enable %0b", level, dut.wr_en);
            end
        end
    end

    initial begin
        logic [7:0]  model_q [$];
        logic [7:0]  front;
        logic [31:0] w;
        int          popped;
        int          words_sent;
        int          cyc;

        rst = 1'b1; flush = 1'b0; s_data = 32'd0; s_drdy = 1'b0; spi_done = 1'b0;

        //           drdy  data           done  din    lvl    busy  empty ovf   unf
        vecs[0]  = '{1'b0, 32'd0,         1'b1, 8'hFF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 32'd0,         1'b1, 8'hFF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 32'd0,         1'b1, 8'hFF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 32'd0,         1'b0, 8'hFF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'hDEADBEEF,  1'b0, 8'hFF, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'd0,         1'b0, 8'hDE, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'd0,         1'b0, 8'hDE, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'd0,         1'b0, 8'hDE, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'd0,         1'b0, 8'hDE, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'd0,         1'b1, 8'hAD, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'd0,         1'b1, 8'hBE, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'd0,         1'b1, 8'hEF, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'd0,         1'b1, 8'hFF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 32'd0,         1'b1, 8'hFF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_din", {24'd0, spi_din}, 32'h0000_00FF);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_level", {27'd0, level}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset-state underflow and single-word round trip, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].drdy, vecs[i].data, vecs[i].done, 1'b0);
            chk($sformatf("vec%0d_din", i), {24'd0, spi_din}, {24'd0, vecs[i].din});
            chk($sformatf("vec%0d_level", i), {27'd0, level}, {27'd0, vecs[i].lvl});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
            chk($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].empty});
            chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
            chk($sformatf("vec%0d_unf", i), {31'd0, underflow}, {31'd0, vecs[i].unf});
        end

        // Fill to 16 bytes, then an extra word must be dropped.
        push_word(32'h00010203);
        push_word(32'h04050607);
        push_word(32'h08090A0B);
        chk("fill12_busy", {31'd0, busy}, 32'd0);
        push_word(32'h0C0D0E0F);
        chk("fill_level", {27'd0, level}, 32'd16);
        chk("fill_busy", {31'd0, busy}, 32'd1);
        step(1'b1, 32'hDEAD0000, 1'b0, 1'b0);
        chk("ovf_pulse", {31'd0, overflow}, 32'd1);
        chk("ovf_level", {27'd0, level}, 32'd16);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("ovf_clear", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), {24'd0, spi_din}, i);
            step(1'b0, 32'd0, 1'b1, 1'b0);
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_idle", {24'd0, spi_din}, 32'h0000_00FF);

        // Near-full streaming with pops during PUSH; 16 words = 4 pointer wraps.
        popped = 0;
        words_sent = 0;
        cyc = 0;
        while ((words_sent < 16 || model_q.size() != 0) && cyc < 3000) begin
            logic dr, dn;
            dr = (words_sent < 16) && !busy;
            dn = (level > 5'd12) || (words_sent >= 16 && level != 5'd0);
            w  = {8'(words_sent*4), 8'(words_sent*4+1), 8'(words_sent*4+2), 8'(words_sent*4+3)};
            if (dn) begin
                front = model_q.pop_front();
                chk($sformatf("stream%0d", popped), {24'd0, spi_din}, {24'd0, front});
                popped++;
            end
            if (dr) begin
                for (int b = 0; b < 4; b++) model_q.push_back(w[31 - 8*b -: 8]);
                words_sent++;
            end
            step(dr, w, dn, 1'b0);
            cyc++;
        end
        chk("stream_count", popped, 32'd64);
        chk("stream_level", {27'd0, level}, 32'd0);

        // Flush after two bytes, with coincident s_drdy and spi_done.
        step(1'b1, 32'h11223344, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("preflush_level", {27'd0, level}, 32'd2);
        step(1'b1, 32'h55667788, 1'b1, 1'b1);
        chk("flush_level", {27'd0, level}, 32'd0);
        chk("flush_din", {24'd0, spi_din}, 32'h0000_00FF);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_ovf", {31'd0, overflow}, 32'd0);
        chk("flush_unf", {31'd0, underflow}, 32'd0);
        push_word(32'hA5A5A5A5);
        chk("postflush_level", {27'd0, level}, 32'd4);
        drain_word("postflush", 32'hA5A5A5A5);

        // Asynchronous reset between edges during PUSH.
        step(1'b1, 32'h12345678, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("prerst_level", {27'd0, level}, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_level", {27'd0, level}, 32'd0);
        chk("arst_din", {24'd0, spi_din}, 32'h0000_00FF);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_empty", {31'd0, empty}, 32'd1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        push_word(32'hCAFEF00D);
        chk("postrst_level", {27'd0, level}, 32'd4);
        drain_word("postrst", 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
